// File: rtl/ifu_fetch.sv
// ============================================================================
//  Module   : ifu_fetch
//  Brief    : Multicycle instruction fetch unit. Fetches one instruction at a
//             time, hands it to decode and waits for execute to retire it
//             before redirecting/advancing the PC.
//             Optional: define IFU_MISALIGN_CHECK_EN to trap misaligned PCs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exu_done,
    input  logic        ecall_taken,
    input  logic [31:0] ecall_target,
    input  logic        mret_taken,
    input  logic [31:0] mret_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RSP  = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4;
`ifdef IFU_MISALIGN_CHECK_EN
    localparam logic [2:0] S_FAULT = 3'd5;
`endif

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic [31:0] w_next_pc;

    // Redirect priority: trap entry beats trap return beats control flow.
    always_comb begin
        if (ecall_taken) begin
            w_next_pc = ecall_target;
        end else if (mret_taken) begin
            w_next_pc = mret_target;
        end else if (branch_taken) begin
            w_next_pc = branch_target;
        end else begin
            w_next_pc = r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= '0;
            r_inst_pc <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (imem_req_ready) begin
                        r_state <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (imem_rsp_valid) begin
                        r_inst    <= imem_rsp_data;
                        r_inst_pc <= r_pc;
                        r_state   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exu_done) begin
                        r_pc <= w_next_pc;
`ifdef IFU_MISALIGN_CHECK_EN
                        r_state <= (w_next_pc[1:0] != 2'b00) ? S_FAULT : S_REQ;
`else
                        r_state <= S_REQ;
`endif
                    end
                end
`ifdef IFU_MISALIGN_CHECK_EN
                S_FAULT: r_state <= S_FAULT;
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are forced quiet during reset, even before the state register clears.
    assign imem_req_valid = ~rst & (r_state == S_REQ);
    assign imem_req_addr  = rst ? RESET_PC : r_pc;
    assign inst_valid     = ~rst & (r_state == S_OUT);
    assign inst           = rst ? 32'h0 : r_inst;
    assign inst_pc        = rst ? 32'h0 : r_inst_pc;

`ifdef IFU_MISALIGN_CHECK_EN
    assign fetch_fault = ~rst & (r_state == S_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
//  Module   : tb_ifu_fetch
//  Brief    : Self-checking bench for ifu_fetch (vector table + scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

    localparam logic [31:0] C_RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exu_done = 1'b0;
    logic        ecall_taken = 1'b0;
    logic [31:0] ecall_target = '0;
    logic        mret_taken = 1'b0;
    logic [31:0] mret_target = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        ec;
        logic        mr;
        logic        br;
        logic [31:0] ect;
        logic [31:0] mrt;
        logic [31:0] brt;
        int          req_stall;
        int          rsp_lat;
        int          out_stall;
        logic        spur;
        logic [31:0] exp_next;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[9];

    ifu_fetch #(.RESET_PC(C_RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .exu_done       (exu_done),
        .ecall_taken    (ecall_taken),
        .ecall_target   (ecall_target),
        .mret_taken     (mret_taken),
        .mret_target    (mret_target),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
        chk({tag, "_req_addr"}, imem_req_addr, C_RESET_PC);
        chk({tag, "_inst_valid"}, {31'h0, inst_valid}, 32'h0);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
        chk({tag, "_fault"}, {31'h0, fetch_fault}, 32'h0);
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        chk("req_timeout", {31'h0, imem_req_valid}, 32'h1);
        chk("req_addr", imem_req_addr, exp_addr);
    endtask

    // One fetch from request through delivery to decode; leaves DUT in execute.
    task automatic fetch_one(input logic [31:0] exp_addr, input vec_t v);
        sb_t e;
        wait_req(exp_addr);
        for (int i = 0; i < v.req_stall; i++) begin
            if (v.spur && i == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            step();
            imem_rsp_valid = 1'b0;
            chk("stall_req_valid", {31'h0, imem_req_valid}, 32'h1);
            chk("stall_req_addr", imem_req_addr, exp_addr);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        if (v.spur) begin
            exu_done     = 1'b1;
            branch_taken = 1'b1;
            branch_target = 32'h1234_5670;
            step();
            exu_done     = 1'b0;
            branch_taken = 1'b0;
            chk("spur_exu_req_valid", {31'h0, imem_req_valid}, 32'h0);
            chk("spur_exu_inst_valid", {31'h0, inst_valid}, 32'h0);
            chk("spur_exu_pc", imem_req_addr, exp_addr);
        end
        for (int i = 1; i < v.rsp_lat; i++) step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = v.data;
        sb_q.push_back('{inst: v.data, pc: exp_addr});
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hBAD0_BAD0;
        chk("inst_valid_up", {31'h0, inst_valid}, 32'h1);
        for (int i = 0; i < v.out_stall; i++) begin
            step();
            chk("hold_inst_valid", {31'h0, inst_valid}, 32'h1);
            chk("hold_inst", inst, v.data);
            chk("hold_inst_pc", inst_pc, exp_addr);
        end
        inst_ready = 1'b1;
        if (inst_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'h0, 32'h1);
            end else begin
                e = sb_q.pop_front();
                chk("sb_inst", inst, e.inst);
                chk("sb_inst_pc", inst_pc, e.pc);
            end
        end
        step();
        inst_ready = 1'b0;
        chk("inst_valid_drop", {31'h0, inst_valid}, 32'h0);
        chk("no_req_in_exec", {31'h0, imem_req_valid}, 32'h0);
    endtask

    task automatic retire(input vec_t v);
        if (v.spur) begin
            ecall_taken  = 1'b1;
            ecall_target = 32'h0BAD_0000;
            step();
            step();
            ecall_taken = 1'b0;
            chk("taken_no_done_req", {31'h0, imem_req_valid}, 32'h0);
        end
        step();
        exu_done      = 1'b1;
        ecall_taken   = v.ec;
        ecall_target  = v.ect;
        mret_taken    = v.mr;
        mret_target   = v.mrt;
        branch_taken  = v.br;
        branch_target = v.brt;
        step();
        exu_done     = 1'b0;
        ecall_taken  = 1'b0;
        mret_taken   = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_addr;
        vec_t v;

        //          data          ec    mr    br    ect            mrt            brt            rs rl os spur  next
        vecs[0] = '{32'h0010_0093, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         0, 1, 0, 1'b0, 32'h8000_0004};
        vecs[1] = '{32'h0020_0113, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         3, 2, 2, 1'b0, 32'h8000_0008};
        vecs[2] = '{32'h0000_0073, 1'b1, 1'b1, 1'b1, 32'h8000_1000, 32'h8000_2000, 32'h8000_3000, 0, 1, 0, 1'b0, 32'h8000_1000};
        vecs[3] = '{32'h3020_0073, 1'b0, 1'b1, 1'b1, 32'h8000_1000, 32'h8000_2000, 32'h8000_3000, 1, 1, 1, 1'b0, 32'h8000_2000};
        vecs[4] = '{32'h0000_0463, 1'b0, 1'b0, 1'b1, 32'h8000_1000, 32'h8000_2000, 32'h8000_3000, 0, 3, 0, 1'b0, 32'h8000_3000};
        vecs[5] = '{32'hFFDF_F06F, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         32'hFFFF_FFFC, 0, 1, 0, 1'b0, 32'hFFFF_FFFC};
        vecs[6] = '{32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         0, 1, 0, 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h0000_0073, 1'b1, 1'b0, 1'b0, 32'h8000_0040, 32'h0,         32'h0,         2, 2, 1, 1'b1, 32'h8000_0040};
        vecs[8] = '{32'h0050_0293, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         1, 1, 0, 1'b1, 32'h8000_0044};

        rst = 1'b1;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;

        exp_addr = C_RESET_PC;
        for (int i = 0; i < 9; i++) begin
            fetch_one(exp_addr, vecs[i]);
            retire(vecs[i]);
            exp_addr = vecs[i].exp_next;
        end

        // Reset while a response is outstanding; the late response must be dropped.
        wait_req(exp_addr);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        chk_reset_outputs("midreset");
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        step();
        imem_rsp_valid = 1'b0;
        chk("stale_rsp_inst_valid", {31'h0, inst_valid}, 32'h0);
        v = '{32'h0030_0193, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_0102, 1, 1, 0, 1'b1, 32'h8000_0102};
        fetch_one(C_RESET_PC, v);
        retire(v);

`ifdef IFU_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            chk("fault_flag", {31'h0, fetch_fault}, 32'h1);
            chk("fault_no_req", {31'h0, imem_req_valid}, 32'h0);
            chk("fault_no_inst", {31'h0, inst_valid}, 32'h0);
            step();
        end
`else
        wait_req(32'h8000_0102);
        chk("no_fault", {31'h0, fetch_fault}, 32'h0);
`endif

        chk("sb_drained", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
